// File: rtl/ps2_dev_tx.sv
// +----------------------------------------------------------------------------+
// | ps2_dev_tx : PS/2 device-side transmitter with word FIFO and host inhibit |
// | Revision   : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps2_dev_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int HALF_PER   = 50,
  parameter int PARITY_ODD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inhibit,
  output logic              ps2_clk,
  output logic              ps2_data,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic              tx_done,
  output logic              overflow
);

  localparam int NBITS = DATA_W + 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(2 * HALF_PER);
  localparam int IDX_W = $clog2(NBITS);

  localparam logic [CNT_W-1:0] C_HALF_LAST  = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(2 * HALF_PER - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NBITS - 1);
  localparam logic [OCC_W-1:0] C_FULL       = OCC_W'(FIFO_DEPTH);
  localparam logic             C_ODD        = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIGH  = 3'd1,
    S_LOW   = 3'd2,
    S_DONE  = 3'd3,
    S_GUARD = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              do_push;
  logic              do_pop;

  // Serialiser
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NBITS-1:0]  sh_q, sh_d;
  logic              ps2_clk_q, ps2_clk_d;
  logic              ps2_data_q, ps2_data_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;

  logic [DATA_W-1:0] head;
  logic              parity;
  logic [NBITS-1:0]  frame;

  assign head   = mem_q[rd_ptr_q];
  assign parity = (^head) ^ C_ODD;
  assign frame  = {1'b1, parity, head, 1'b0};

  // A write into a full FIFO survives only if the head leaves on the same edge.
  always_comb begin
    do_push    = wr_en && (!full_q || do_pop);
    overflow_d = wr_en && full_q && !do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == C_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    do_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !inhibit) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          idx_d   = '0;
          sh_d    = frame;
        end
      end
      S_HIGH: begin
        if (inhibit) begin
          state_d = S_GUARD;
          cnt_d   = '0;
        end else if (cnt_q == C_HALF_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (inhibit) begin
          state_d = S_GUARD;
          cnt_d   = '0;
        end else if (cnt_q == C_HALF_LAST) begin
          cnt_d = '0;
          if (idx_q != C_IDX_LAST) begin
            state_d = S_HIGH;
            idx_d   = idx_q + IDX_W'(1);
            sh_d    = {1'b1, sh_q[NBITS-1:1]};
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // The frame is already on the wire, so inhibit cannot cancel the pop.
        do_pop  = 1'b1;
        state_d = S_GUARD;
        cnt_d   = '0;
      end
      S_GUARD: begin
        if (inhibit) begin
          cnt_d = '0;
        end else if (cnt_q == C_GUARD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    ps2_clk_d  = (state_d != S_LOW);
    ps2_data_d = (state_d == S_HIGH || state_d == S_LOW) ? sh_d[0] : 1'b1;
    busy_d     = (state_d != S_IDLE);
    tx_done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign tx_done  = tx_done_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_dev_tx.sv
// Testbench for ps2_dev_tx: scoreboard of expected frames against frames
// reconstructed from the PS/2 lines at each falling ps2_clk edge.
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_dev_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int HP    = 4;
  localparam int NB    = DW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          inhibit = 1'b0;
  logic          ps2_clk, ps2_data, busy, full, empty, tx_done, overflow;

  logic          wr_en2 = 1'b0;
  logic [DW-1:0] wr_data2 = '0;
  logic          inhibit2 = 1'b0;
  logic          ps2_clk_2, ps2_data_2, busy_2, full_2, empty_2, tx_done_2, overflow_2;

  always #5 clk = ~clk;

  ps2_dev_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .HALF_PER(HP), .PARITY_ODD(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .inhibit(inhibit),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .full(full), .empty(empty),
    .tx_done(tx_done), .overflow(overflow)
  );

  ps2_dev_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .HALF_PER(HP), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_data(wr_data2), .inhibit(inhibit2),
    .ps2_clk(ps2_clk_2), .ps2_data(ps2_data_2), .busy(busy_2), .full(full_2), .empty(empty_2),
    .tx_done(tx_done_2), .overflow(overflow_2)
  );

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          start_cyc;
    int          done_cyc;
  } obs_t;

  obs_t        obs_q[$];
  logic [10:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  int          cyc = 0, starts = 0, dones = 0;
  logic [15:0] cur_bits = '0;
  int          cur_n = 0, cur_start = 0;
  logic        prev_clk = 1'b1, prev_data = 1'b1;

  // Frame reconstruction: a start is data falling while the clock stayed high.
  always begin
    @(posedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      cur_n = 0; cur_bits = '0; prev_clk = 1'b1; prev_data = 1'b1;
    end else begin
      cyc++;
      if (prev_clk && ps2_clk && prev_data && !ps2_data) begin
        cur_n = 0; cur_bits = '0; cur_start = cyc; starts++;
      end
      if (prev_clk && !ps2_clk) begin
        if (cur_n < 16) cur_bits[cur_n] = ps2_data;
        cur_n++;
      end
      if (tx_done) begin
        obs_q.push_back('{cur_bits, cur_n, cur_start, cyc});
        dones++;
      end
      prev_clk = ps2_clk; prev_data = ps2_data;
    end
  end

  logic [15:0] bits2 = '0, last2 = '0;
  int          n2 = 0, last2_n = 0, dones2 = 0;
  logic        pc2 = 1'b1;

  always begin
    @(posedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      n2 = 0; bits2 = '0; pc2 = 1'b1;
    end else begin
      if (pc2 && !ps2_clk_2) begin
        if (n2 < 16) bits2[n2] = ps2_data_2;
        n2++;
      end
      if (tx_done_2) begin
        last2 = bits2; last2_n = n2; dones2++; n2 = 0; bits2 = '0;
      end
      pc2 = ps2_clk_2;
    end
  end

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit odd);
    int   ones = 0;
    logic p;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    p = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic write1(input logic [7:0] d, input bit accepted);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (accepted) exp_q.push_back(make_frame(d, 1'b1));
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin @(negedge clk); k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ps2_clk !== 1'b1)  begin errors++; $display("FAIL reset_ps2_clk got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL reset_ps2_data got %b want 1", ps2_data); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (tx_done !== 1'b0)  begin errors++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    obs_t        o;
    logic [10:0] e;
    bit          ok;
    int          d0 = dones;
    write1(8'h1C, 1'b1);
    wait_obs(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d frames want 1", obs_q.size()); end
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o.bits[10:0] !== e) begin errors++; $display("FAIL single_bits got %h want %h", o.bits[10:0], e); end
      checks++; if (o.bits[10:0] !== 11'h438) begin errors++; $display("FAIL single_1c_pattern got %h want 438", o.bits[10:0]); end
      checks++; if (o.nbits !== NB) begin errors++; $display("FAIL single_edges got %0d want %0d", o.nbits, NB); end
      checks++; if (o.done_cyc - o.start_cyc !== 88) begin errors++; $display("FAIL single_length got %0d want 88", o.done_cyc - o.start_cyc); end
    end
    wait_idle(40, ok);
    repeat (5) @(negedge clk);
    checks++; if (dones - d0 !== 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", dones - d0); end
  endtask

  task automatic test_parity();
    obs_t o;
    bit   ok;
    int   d2 = dones2;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h00; wr_en2 = 1'b1; wr_data2 = 8'h00;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_en2 = 1'b0;
    exp_q.push_back(make_frame(8'h00, 1'b1));
    wait_obs(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL parity_timeout got %0d frames want 1", obs_q.size()); end
    if (ok) begin
      o = obs_q.pop_front(); void'(exp_q.pop_front());
      checks++; if (o.bits[9] !== 1'b1)  begin errors++; $display("FAIL parity_odd_bit got %b want 1", o.bits[9]); end
      checks++; if (o.bits[10] !== 1'b1) begin errors++; $display("FAIL parity_odd_stop got %b want 1", o.bits[10]); end
    end
    repeat (5) @(negedge clk);
    checks++; if (dones2 - d2 !== 1) begin errors++; $display("FAIL parity_even_done got %0d want 1", dones2 - d2); end
    checks++; if (last2[10:0] !== make_frame(8'h00, 1'b0)) begin errors++; $display("FAIL parity_even_frame got %h want %h", last2[10:0], make_frame(8'h00, 1'b0)); end
    checks++; if (last2[9] !== 1'b0 || last2[10] !== 1'b1) begin errors++; $display("FAIL parity_even_bits got p%b s%b want p0 s1", last2[9], last2[10]); end
    wait_idle(40, ok);
  endtask

  task automatic test_fifo_full();
    obs_t        o, prev;
    logic [10:0] e;
    bit          ok;
    @(negedge clk); inhibit = 1'b1;
    write1(8'h11, 1'b1); write1(8'h22, 1'b1); write1(8'h33, 1'b1); write1(8'h44, 1'b1);
    @(negedge clk);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fifo_full got %b want 1", full); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fifo_inhibit_busy got %b want 0", busy); end
    write1(8'h55, 1'b0);
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fifo_overflow got %b want 1", overflow); end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fifo_overflow_pulse got %b want 0", overflow); end
    inhibit = 1'b0;
    wait_obs(4, 700, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fifo_timeout got %0d frames want 4", obs_q.size()); end
    for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o.bits[10:0] !== e) begin errors++; $display("FAIL fifo_frame%0d got %h want %h", i, o.bits[10:0], e); end
      if (i > 0) begin
        checks++;
        if (o.start_cyc - prev.done_cyc - 1 !== 9) begin
          errors++; $display("FAIL fifo_gap%0d got %0d want 9", i, o.start_cyc - prev.done_cyc - 1);
        end
      end
      prev = o;
    end
    wait_idle(40, ok);
    @(negedge clk);
    checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fifo_drained got empty=%b busy=%b want 1 0", empty, busy); end
  endtask

  task automatic test_inhibit_abort();
    obs_t        o;
    logic [10:0] e;
    bit          ok;
    int          s0 = starts, d0, s, rel, k;
    write1(8'hA5, 1'b1);
    k = 0;
    while (starts == s0 && k < 50) begin @(negedge clk); k++; end
    s = cur_start;
    // Bit 5 is on the wire from start+40 to start+47; inhibit lands mid high half.
    k = 0;
    while (cyc < s + 41 && k < 100) begin @(negedge clk); k++; end
    d0 = dones;
    inhibit = 1'b1;
    @(negedge clk);
    checks++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin errors++; $display("FAIL abort_lines got clk=%b data=%b want 1 1", ps2_clk, ps2_data); end
    repeat (19) @(negedge clk);
    checks++; if (dones !== d0 || busy !== 1'b1) begin errors++; $display("FAIL abort_no_done got dones+%0d busy=%b want +0 1", dones - d0, busy); end
    s0 = starts;
    inhibit = 1'b0;
    rel = cyc;
    wait_obs(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_timeout got %0d frames want 1", obs_q.size()); end
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o.bits[10:0] !== e || o.nbits !== NB) begin errors++; $display("FAIL abort_resend got %h/%0d want %h/%0d", o.bits[10:0], o.nbits, e, NB); end
      // 8 guard cycles after release, then one idle cycle before the start bit.
      checks++; if (o.start_cyc - rel !== 9) begin errors++; $display("FAIL abort_restart_delay got %0d want 9", o.start_cyc - rel); end
    end
    wait_idle(40, ok);
    checks++; if (dones - d0 !== 1) begin errors++; $display("FAIL abort_done_count got %0d want 1", dones - d0); end
  endtask

  task automatic test_push_pop_full();
    obs_t        o;
    logic [10:0] e;
    bit          ok;
    int          k;
    @(negedge clk); inhibit = 1'b1;
    write1(8'h3C, 1'b1); write1(8'hC3, 1'b1); write1(8'h81, 1'b1); write1(8'h7E, 1'b1);
    @(negedge clk); inhibit = 1'b0;
    k = 0;
    while (!tx_done && k < 200) begin @(negedge clk); k++; end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL pushpop_done_timeout got %b want 1", tx_done); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL pushpop_full_before got %b want 1", full); end
    wr_en = 1'b1; wr_data = 8'h66;
    @(posedge clk); #1;
    wr_en = 1'b0;
    exp_q.push_back(make_frame(8'h66, 1'b1));
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow got %b want 0", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL pushpop_full_after got %b want 1", full); end
    wait_obs(5, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pushpop_timeout got %0d frames want 5", obs_q.size()); end
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o.bits[10:0] !== e) begin errors++; $display("FAIL pushpop_frame%0d got %h want %h", i, o.bits[10:0], e); end
    end
    wait_idle(40, ok);
  endtask

  task automatic test_reset_midframe();
    int s0 = starts, k, d0;
    write1(8'h5A, 1'b0);
    k = 0;
    while (starts == s0 && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (cyc < cur_start + 21 && k < 100) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    #1;
    checks++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin errors++; $display("FAIL midrst_lines got clk=%b data=%b want 1 1", ps2_clk, ps2_data); end
    checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state got empty=%b busy=%b want 1 0", empty, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = starts; d0 = dones;
    repeat (150) @(negedge clk);
    checks++; if (starts !== s0 || dones !== d0 || ps2_data !== 1'b1) begin errors++; $display("FAIL midrst_quiet got starts+%0d dones+%0d data=%b want +0 +0 1", starts - s0, dones - d0, ps2_data); end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midrst_stray_frames got %0d want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_fifo_full();
    test_inhibit_abort();
    test_push_pop_full();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
